opb_register_bank_ppc2simulink: RTL

Parametrised OPB slave register bank: successor to the single-register PPC-to-Simulink software register. It exposes `C_NUM_REGS` 32-bit control registers to the PowerPC over OPB, with byte-enable writes and full readback. All registers drive the user fabric from one flat output bus, with a per-register one-cycle update strobe. An optional shadow/commit mode updates all registers to the fabric atomically.

---
 rtl/opb_register_bank_ppc2simulink.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS 32-bit control registers driving a flat fabric bus with per-register strobes.
// Optional macro OPB_REGBANK_SHADOW_EN: writes land in shadows, a write to offset C_NUM_REGS commits all of them.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 8,
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_strobe
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_s, off_s, wdata_s, rdata_d, rdata_q;
  logic [29:0]           idx_s;
  logic [3:0]            be_s;
  logic                  hit_s, wr_s, commit_s, unused_s;
  logic [C_NUM_REGS-1:0] strobe_d, strobe_q;
  logic [31:0]           fab_q [C_NUM_REGS];
`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0]           shd_q [C_NUM_REGS];
`endif

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // OPB bit 0 is the MSB, so the numeric value of each bus already matches register bit order
  assign addr_s   = 32'(OPB_ABus);
  assign wdata_s  = 32'(OPB_DBus);
  assign be_s     = OPB_BE;
  assign off_s    = addr_s - C_BASEADDR;
  assign idx_s    = off_s[31:2];
  assign unused_s = ^{OPB_seqAddr, off_s[1:0]};

  // Next-state logic; a hit is only recognised in IDLE so a held select cannot retrigger
  always_comb begin
    state_d = state_q;
    hit_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (OPB_select && (addr_s >= C_BASEADDR) && (addr_s <= C_HIGHADDR)) begin
          hit_s   = 1'b1;
          state_d = ACK;
        end else begin
          hit_s   = 1'b0;
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write decode, read mux and strobe generation
  always_comb begin
    wr_s     = hit_s && !OPB_RNW && (idx_s < 30'(C_NUM_REGS));
    commit_s = 1'b0;
    rdata_d  = 32'h0000_0000;
    strobe_d = '0;
`ifdef OPB_REGBANK_SHADOW_EN
    commit_s = hit_s && !OPB_RNW && (idx_s == 30'(C_NUM_REGS));
    strobe_d = commit_s ? '1 : '0;
`endif
    for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef OPB_REGBANK_SHADOW_EN
      rdata_d = rdata_d | ((hit_s && OPB_RNW && (idx_s == 30'(i))) ? shd_q[i] : 32'h0000_0000);
`else
      rdata_d = rdata_d | ((hit_s && OPB_RNW && (idx_s == 30'(i))) ? fab_q[i] : 32'h0000_0000);
      strobe_d[i] = wr_s && (idx_s == 30'(i));
`endif
    end
  end

  // FSM state, registered read data and strobes
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= IDLE;
      rdata_q  <= 32'h0000_0000;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
    end
  end

  // Register storage; the fabric copy follows either the write itself or a commit
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        fab_q[i] <= C_RESET_VALUE;
`ifdef OPB_REGBANK_SHADOW_EN
        shd_q[i] <= C_RESET_VALUE;
`endif
      end
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef OPB_REGBANK_SHADOW_EN
        if (wr_s && (idx_s == 30'(i))) begin
          shd_q[i] <= merge_be(shd_q[i], wdata_s, be_s);
        end
        if (commit_s) begin
          fab_q[i] <= shd_q[i];
        end
`else
        if (wr_s && (idx_s == 30'(i))) begin
          fab_q[i] <= merge_be(fab_q[i], wdata_s, be_s);
        end
`endif
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = fab_q[g];
  end

  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = (state_q == ACK);
  assign user_strobe = strobe_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule
